// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: command codes,
// instruction modes, condition codes, status-register bit positions and the ID/EX payload.
package id_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 4;
    localparam int unsigned NUM_REGS = 15;
    localparam logic [REG_AW-1:0] PC_REG = 4'd15;

    localparam int unsigned SR_V = 0;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_N = 3;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000, EXE_MOV = 4'b0001, EXE_ADD = 4'b0010, EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100, EXE_SBC = 4'b0101, EXE_AND = 4'b0110, EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000, EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        MODE_ARITH = 2'b00, MODE_MEM = 2'b01, MODE_BRANCH = 2'b10, MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_e;

    localparam logic [3:0] OPC_AND = 4'b0000;
    localparam logic [3:0] OPC_EOR = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_ADD = 4'b0100;
    localparam logic [3:0] OPC_ADC = 4'b0101;
    localparam logic [3:0] OPC_SBC = 4'b0110;
    localparam logic [3:0] OPC_TST = 4'b1000;
    localparam logic [3:0] OPC_CMP = 4'b1010;
    localparam logic [3:0] OPC_ORR = 4'b1100;
    localparam logic [3:0] OPC_MOV = 4'b1101;
    localparam logic [3:0] OPC_MVN = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   val_rn;
        logic [XLEN-1:0]   val_rm;
        logic [REG_AW-1:0] dest;
        exe_cmd_e          exe_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              s;
        logic              b;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic              carry;
    } id_ex_t;

    // Evaluate a condition field against the {N,Z,C,V} status flags.
    function automatic logic cond_pass(input cond_e cond, input logic [3:0] sr);
        logic n, z, c, v, pass;
        n = sr[SR_N];
        z = sr[SR_Z];
        c = sr[SR_C];
        v = sr[SR_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 15x32 general register file: one write port, two read ports with write-through
// bypass; address 15 reads back the PC+4 value instead of storage.
module id_stage_register_file
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN-1:0]   pc_plus_four,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [XLEN-1:0]   rd_data_a_c,
    output logic [XLEN-1:0]   rd_data_b_c
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic            wr_hit;

    assign wr_hit = wr_en && (wr_addr != PC_REG);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // R15 is the PC; otherwise a same-cycle write to the read address is forwarded.
    assign rd_data_a_c = (rd_addr_a == PC_REG)              ? pc_plus_four :
                         (wr_hit && (wr_addr == rd_addr_a)) ? wr_data      :
                                                              regs_q[rd_addr_a];
    assign rd_data_b_c = (rd_addr_b == PC_REG)              ? pc_plus_four :
                         (wr_hit && (wr_addr == rd_addr_b)) ? wr_data      :
                                                              regs_q[rd_addr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode, condition check, register read and
// the ID/EX pipeline register with freeze/flush/hazard handling.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   instruction_in,
    input  logic [XLEN-1:0]   pc_plus_four_in,
    input  logic              freeze_in,
    input  logic              flush_in,
    input  logic              hazard_in,
    input  logic [3:0]        sr_in,
    input  logic              wb_en_in,
    input  logic [REG_AW-1:0] wb_dest_in,
    input  logic [XLEN-1:0]   wb_value_in,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              two_src_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   val_rn_out,
    output logic [XLEN-1:0]   val_rm_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              s_out,
    output logic              b_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic              carry_out
);

    cond_e             cond;
    mode_e             mode;
    logic              i_bit;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rm;
    logic              is_str;
    logic              cond_ok;
    logic [XLEN-1:0]   val_rn_c;
    logic [XLEN-1:0]   val_rm_c;
    id_ex_t            dec;
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;

    assign cond    = cond_e'(instruction_in[31:28]);
    assign mode    = mode_e'(instruction_in[27:26]);
    assign i_bit   = instruction_in[25];
    assign opcode  = instruction_in[24:21];
    assign s_bit   = instruction_in[20];
    assign rn      = instruction_in[19:16];
    assign rd      = instruction_in[15:12];
    assign rm      = instruction_in[3:0];
    assign is_str  = (mode == MODE_MEM) && !s_bit;
    assign cond_ok = cond_pass(cond, sr_in);

    assign src1_out    = rn;
    assign src2_out    = is_str ? rd : rm;
    assign two_src_out = ((mode == MODE_ARITH) && !i_bit) || is_str;

    id_stage_register_file u_register_file (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wb_en_in),
        .wr_addr      (wb_dest_in),
        .wr_data      (wb_value_in),
        .pc_plus_four (pc_plus_four_in),
        .rd_addr_a    (src1_out),
        .rd_addr_b    (src2_out),
        .rd_data_a_c  (val_rn_c),
        .rd_data_b_c  (val_rm_c)
    );

    // Decode; s follows the S bit only for data-processing instructions.
    always_comb begin
        dec               = '0;
        dec.pc            = pc_plus_four_in;
        dec.val_rn        = val_rn_c;
        dec.val_rm        = val_rm_c;
        dec.dest          = rd;
        dec.imm           = i_bit;
        dec.shift_operand = instruction_in[11:0];
        dec.signed_imm_24 = instruction_in[23:0];
        dec.carry         = sr_in[SR_C];
        case (mode)
            MODE_ARITH: begin
                dec.wb_en = 1'b1;
                dec.s     = s_bit;
                case (opcode)
                    OPC_MOV: dec.exe_cmd = EXE_MOV;
                    OPC_MVN: dec.exe_cmd = EXE_MVN;
                    OPC_ADD: dec.exe_cmd = EXE_ADD;
                    OPC_ADC: dec.exe_cmd = EXE_ADC;
                    OPC_SUB: dec.exe_cmd = EXE_SUB;
                    OPC_SBC: dec.exe_cmd = EXE_SBC;
                    OPC_AND: dec.exe_cmd = EXE_AND;
                    OPC_ORR: dec.exe_cmd = EXE_ORR;
                    OPC_EOR: dec.exe_cmd = EXE_EOR;
                    OPC_CMP: begin
                        dec.exe_cmd = EXE_SUB;
                        dec.wb_en   = 1'b0;
                        dec.s       = 1'b1;
                    end
                    OPC_TST: begin
                        dec.exe_cmd = EXE_AND;
                        dec.wb_en   = 1'b0;
                        dec.s       = 1'b1;
                    end
                    default: dec.exe_cmd = EXE_NOP;
                endcase
            end
            MODE_MEM: begin
                dec.exe_cmd  = EXE_ADD;
                dec.mem_r_en = s_bit;
                dec.wb_en    = s_bit;
                dec.mem_w_en = !s_bit;
            end
            MODE_BRANCH: dec.b = 1'b1;
            default: ;
        endcase
        if (!cond_ok || hazard_in) begin
            dec.wb_en    = 1'b0;
            dec.mem_r_en = 1'b0;
            dec.mem_w_en = 1'b0;
            dec.b        = 1'b0;
            dec.s        = 1'b0;
        end
    end

    always_comb begin
        id_ex_d = id_ex_q;
        if (freeze_in) begin
            id_ex_d = id_ex_q;
        end else if (flush_in) begin
            id_ex_d = '0;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign pc_out            = id_ex_q.pc;
    assign val_rn_out        = id_ex_q.val_rn;
    assign val_rm_out        = id_ex_q.val_rm;
    assign dest_out          = id_ex_q.dest;
    assign exe_cmd_out       = id_ex_q.exe_cmd;
    assign mem_r_en_out      = id_ex_q.mem_r_en;
    assign mem_w_en_out      = id_ex_q.mem_w_en;
    assign wb_en_out         = id_ex_q.wb_en;
    assign s_out             = id_ex_q.s;
    assign b_out             = id_ex_q.b;
    assign imm_out           = id_ex_q.imm;
    assign shift_operand_out = id_ex_q.shift_operand;
    assign signed_imm_24_out = id_ex_q.signed_imm_24;
    assign carry_out         = id_ex_q.carry;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a behavioural decode/register model.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        s;
        logic        b;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] imm24;
        logic        c;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction_in = '0;
    logic [31:0] pc_plus_four_in = '0;
    logic        freeze_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        hazard_in = 1'b0;
    logic [3:0]  sr_in = '0;
    logic        wb_en_in = 1'b0;
    logic [3:0]  wb_dest_in = '0;
    logic [31:0] wb_value_in = '0;
    logic [3:0]  src1_out, src2_out;
    logic        two_src_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  dest_out, exe_cmd_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, s_out, b_out, imm_out, carry_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [15];
    bundle_t     m_out;
    logic [3:0]  cmd_tbl [16];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .instruction_in(instruction_in), .pc_plus_four_in(pc_plus_four_in),
        .freeze_in(freeze_in), .flush_in(flush_in), .hazard_in(hazard_in), .sr_in(sr_in),
        .wb_en_in(wb_en_in), .wb_dest_in(wb_dest_in), .wb_value_in(wb_value_in),
        .src1_out(src1_out), .src2_out(src2_out), .two_src_out(two_src_out),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .dest_out(dest_out),
        .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .s_out(s_out), .b_out(b_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .carry_out(carry_out)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bundle_t observed();
        bundle_t o;
        o = '{pc: pc_out, rn: val_rn_out, rm: val_rm_out, dest: dest_out, cmd: exe_cmd_out,
              mr: mem_r_en_out, mw: mem_w_en_out, wb: wb_en_out, s: s_out, b: b_out,
              imm: imm_out, sh: shift_operand_out, imm24: signed_imm_24_out, c: carry_out};
        return o;
    endfunction

    // ARM-style: cond[3:1] picks a base test, cond[0] inverts it; 1111 inverts "always".
    function automatic logic m_cond(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v, base;
        n = sr[3]; z = sr[2]; c = sr[1]; v = sr[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd15) return pc_plus_four_in;
        if (wb_en_in && wb_dest_in == a) return wb_value_in;
        return m_regs[a];
    endfunction

    function automatic bundle_t m_decode();
        bundle_t e;
        logic [31:0] w;
        logic str, cmp_tst;
        w = instruction_in;
        e = '0;
        str = (w[27:26] == 2'b01) && !w[20];
        e.pc = pc_plus_four_in;
        e.rn = m_read(w[19:16]);
        e.rm = m_read(str ? w[15:12] : w[3:0]);
        e.dest = w[15:12];
        e.imm = w[25];
        e.sh = w[11:0];
        e.imm24 = w[23:0];
        e.c = sr_in[1];
        if (w[27:26] == 2'b00) begin
            cmp_tst = (w[24:21] == 4'd10) || (w[24:21] == 4'd8);
            e.cmd = cmd_tbl[w[24:21]];
            e.wb = !cmp_tst;
            e.s = w[20] | cmp_tst;
        end else if (w[27:26] == 2'b01) begin
            e.cmd = 4'd2;
            e.mr = w[20];
            e.wb = w[20];
            e.mw = !w[20];
        end else if (w[27:26] == 2'b10) begin
            e.b = 1'b1;
        end
        if (!m_cond(w[31:28], sr_in) || hazard_in) begin
            e.wb = 0; e.mr = 0; e.mw = 0; e.b = 0; e.s = 0;
        end
        return e;
    endfunction

    // One clock: drive, check the combinational hazard-unit outputs, advance the model, check ID/EX.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic [3:0] sr,
                        input logic frz, input logic fl, input logic hz, input logic r,
                        input logic wbe, input logic [3:0] wbd, input logic [31:0] wbv);
        bundle_t nxt;
        logic str;
        @(negedge clk);
        instruction_in = ins; pc_plus_four_in = pc4; sr_in = sr;
        freeze_in = frz; flush_in = fl; hazard_in = hz; rst = r;
        wb_en_in = wbe; wb_dest_in = wbd; wb_value_in = wbv;
        #1;
        str = (ins[27:26] == 2'b01) && !ins[20];
        check("src", 160'({src1_out, src2_out, two_src_out}),
              160'({ins[19:16], str ? ins[15:12] : ins[3:0], ((ins[27:26] == 2'b00) && !ins[25]) || str}));
        nxt = m_decode();
        if (r) begin
            for (int i = 0; i < 15; i++) m_regs[i] = '0;
            m_out = '0;
        end else begin
            if (wbe && wbd != 4'd15) m_regs[wbd] = wbv;
            if (frz) m_out = m_out;
            else if (fl) m_out = '0;
            else m_out = nxt;
        end
        @(posedge clk);
        #1;
        check("idex", 160'(observed()), 160'(m_out));
    endtask

    task automatic plain(input logic [31:0] ins, input logic [3:0] sr);
        step(ins, 32'h0000_1004, sr, 0, 0, 0, 0, 0, 4'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] held;
        for (int i = 0; i < 16; i++) cmd_tbl[i] = 4'd0;
        cmd_tbl[13] = 4'd1; cmd_tbl[15] = 4'd9; cmd_tbl[4] = 4'd2; cmd_tbl[5] = 4'd3;
        cmd_tbl[2] = 4'd4; cmd_tbl[10] = 4'd4; cmd_tbl[6] = 4'd5; cmd_tbl[0] = 4'd6;
        cmd_tbl[8] = 4'd6; cmd_tbl[12] = 4'd7; cmd_tbl[1] = 4'd8;
        for (int i = 0; i < 15; i++) m_regs[i] = 'x;
        m_out = 'x;

        step(32'hE3A0_0014, 32'h0000_0004, 4'h0, 0, 0, 0, 1, 0, 4'd0, 32'd0);
        check("reset_zero", 160'(observed()), 160'd0);

        plain(32'hE3A0_0014, 4'h0);
        check("mov_cmd", 160'({exe_cmd_out, wb_en_out, imm_out, dest_out}), 160'({4'b0001, 1'b1, 1'b1, 4'd0}));

        step(32'hE084_5004, 32'h0000_1008, 4'h0, 0, 0, 0, 0, 1, 4'd4, 32'd41);
        check("bypass", 160'({val_rn_out, val_rm_out}), 160'({32'd41, 32'd41}));

        plain(32'h1081_1001, 4'b0100);
        check("addne_z1", 160'(wb_en_out), 160'(1'b0));
        plain(32'h1081_1001, 4'b0000);
        check("addne_z0", 160'(wb_en_out), 160'(1'b1));

        plain(32'hE580_1000, 4'h0);
        check("str", 160'({src2_out, two_src_out, mem_w_en_out, wb_en_out}), 160'({4'd1, 1'b1, 1'b1, 1'b0}));

        held = 32'(observed().rm);
        for (int k = 0; k < 3; k++)
            step(32'hE3A0_2055 + 32'(k), 32'h0000_2000, 4'hF, 1, 0, 0, 0, 0, 4'd0, 32'd0);
        check("freeze_hold", 160'({mem_w_en_out, val_rm_out, pc_out}), 160'({1'b1, held, 32'h0000_1004}));
        step(32'hE3A0_2055, 32'h0000_2000, 4'h0, 0, 1, 0, 0, 0, 4'd0, 32'd0);
        check("flush_zero", 160'(observed()), 160'd0);

        step(32'hE590_1000, 32'h0000_3000, 4'h0, 0, 0, 1, 0, 0, 4'd0, 32'd0);
        check("hazard_ldr", 160'({mem_r_en_out, wb_en_out}), 160'({1'b0, 1'b0}));

        step(32'hE3A0_0000, 32'h0000_3004, 4'h0, 1, 0, 0, 1, 0, 4'd0, 32'd0);
        check("rst_over_freeze", 160'(observed()), 160'd0);
        step(32'hE3A0_0000, 32'h0000_3004, 4'h0, 0, 0, 0, 0, 1, 4'd15, 32'hDEAD_BEEF);
        for (int r = 0; r < 15; r += 2)
            plain({4'hE, 8'h08, 4'(r), 4'd0, 8'd0, 4'(r + 1)}, 4'h0);

        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(9));
            ins = $urandom;
            ins[27:26] = (sel < 6) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            if ($urandom_range(1) == 0) ins[31:28] = 4'hE;
            step(ins, $urandom, 4'($urandom), $urandom_range(9) == 0, $urandom_range(11) == 0,
                 $urandom_range(6) == 0, $urandom_range(49) == 0, 1'($urandom),
                 4'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
